// File: rtl/deserializer_pkg.sv
// Shared definitions for the byte-serial link: widths, byte index and receive states.
package deserializer_pkg;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int unsigned SHIFT_W        = WORD_W - BYTE_W;

  typedef logic [IDX_W-1:0] byte_idx_t;

  typedef enum logic {
    HUNT     = 1'b0,
    ASSEMBLE = 1'b1
  } state_t;
endpackage

// File: rtl/deserializer_byte_assembler.sv
// Byte index counter and lane writer; flags word completion and mid-word start-of-word.
module deserializer_byte_assembler
  import deserializer_pkg::*;
#(
  parameter bit REQUIRE_SOF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_8,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic [WORD_W-1:0] word_c,
  output logic              done_c,
  output logic              align_err_c
);

  localparam state_t RST_STATE = REQUIRE_SOF ? HUNT : ASSEMBLE;

  state_t               state_q, state_d;
  byte_idx_t            idx_q, idx_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    done_c      = 1'b0;
    align_err_c = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        // A marker always restarts the word at lane 0; any partial word is dropped.
        align_err_c   = (state_q == ASSEMBLE) && (idx_q != '0);
        state_d       = ASSEMBLE;
        shift_d[7:0]  = data_8;
        idx_d         = byte_idx_t'(1);
      end else if (state_q == ASSEMBLE) begin
        idx_d = idx_q + byte_idx_t'(1);
        case (idx_q)
          2'd0:    shift_d[7:0]   = data_8;
          2'd1:    shift_d[15:8]  = data_8;
          2'd2:    shift_d[23:16] = data_8;
          default: done_c         = 1'b1;
        endcase
      end
    end
  end

  assign word_c = {data_8, shift_q};

endmodule

// File: rtl/deserializer.sv
// 8-to-32 deserializer: byte assembly followed by a single valid/ready output register.
module deserializer
  import deserializer_pkg::*;
#(
  parameter bit REQUIRE_SOF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] data_8,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic [WORD_W-1:0] data_32,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              align_err,
  output logic              overflow
);

  logic [WORD_W-1:0] word_c;
  logic              done_c;
  logic              align_err_c;

  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              align_err_q, align_err_d;
  logic              overflow_q, overflow_d;

  deserializer_byte_assembler #(
    .REQUIRE_SOF (REQUIRE_SOF)
  ) u_assembler (
    .clk         (clk),
    .rst         (rst),
    .data_8      (data_8),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .word_c      (word_c),
    .done_c      (done_c),
    .align_err_c (align_err_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      align_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      align_err_q <= align_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q && !out_ready;
    align_err_d = align_err_c;
    overflow_d  = 1'b0;
    if (done_c) begin
      // A held, unaccepted word wins; the new one is dropped.
      if (!valid_q || out_ready) begin
        data_d  = word_c;
        valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  assign data_32   = data_q;
  assign out_valid = valid_q;
  assign align_err = align_err_q;
  assign overflow  = overflow_q;

endmodule
